ct_mmu_jtlb_sram_ctrl: RTL and testbench

- Access controller for one 256x196 single-port JTLB array in the MMU.
- Arbitrates between a refill writer, two readers (lookup and debug), and an internal invalidate-all sweeper.
- Drives the array's active-low CEN/GWEN/WEN pins from registers and returns read data with a fixed latency.
- Sits between the JTLB control logic and the SRAM macro.

---
 rtl/ct_mmu_jtlb_pkg.sv | 21 ++
 rtl/ct_mmu_jtlb_sweep_fsm.sv | 72 +++++++
 rtl/ct_mmu_jtlb_sram_ctrl.sv | 153 +++++++++++++++
 tb/tb_ct_mmu_jtlb_sram_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_mmu_jtlb_pkg.sv
// Shared constants and encodings for the JTLB array access controller.
package ct_mmu_jtlb_pkg;

    localparam int unsigned ADDR_WIDTH = 8;
    localparam int unsigned DATA_WIDTH = 196;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SWEEP = 2'b01,
        DONE  = 2'b10
    } sweep_state_e;

    typedef enum logic [2:0] {
        SRC_NONE  = 3'd0,
        SRC_SWEEP = 3'd1,
        SRC_WR    = 3'd2,
        SRC_RD0   = 3'd3,
        SRC_RD1   = 3'd4
    } arb_src_e;

endpackage

// File: rtl/ct_mmu_jtlb_sweep_fsm.sv
// Invalidate-all sweeper: walks every index once per pass, restarting the
// pass when a new request lands mid-sweep.
module ct_mmu_jtlb_sweep_fsm #(
    parameter int unsigned ADDR_WIDTH = ct_mmu_jtlb_pkg::ADDR_WIDTH
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  inv_all_req,
    output logic                  busy,
    output logic                  sweep_we,
    output logic [ADDR_WIDTH-1:0] sweep_addr,
    output logic                  inv_all_done
);
    import ct_mmu_jtlb_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    sweep_state_e state;
    logic         restart;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state        <= IDLE;
            sweep_addr   <= '0;
            restart      <= 1'b0;
            busy         <= 1'b0;
            sweep_we     <= 1'b0;
            inv_all_done <= 1'b0;
        end else begin
            inv_all_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (inv_all_req) begin
                        state      <= SWEEP;
                        sweep_addr <= '0;
                        busy       <= 1'b1;
                        sweep_we   <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (sweep_addr == LAST_IDX) begin
                        // A request in the final cycle still forces another pass.
                        sweep_addr <= '0;
                        if (restart || inv_all_req) begin
                            restart <= 1'b0;
                        end else begin
                            state        <= DONE;
                            sweep_we     <= 1'b0;
                            inv_all_done <= 1'b1;
                        end
                    end else begin
                        sweep_addr <= sweep_addr + ADDR_WIDTH'(1);
                        if (inv_all_req) begin
                            restart <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    sweep_we <= 1'b0;
                    restart  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ct_mmu_jtlb_sram_ctrl.sv
// JTLB single-port array controller: arbitrates refill writes, two readers and
// the invalidate sweep onto registered SRAM pins; read data returns two cycles later.
module ct_mmu_jtlb_sram_ctrl #(
    parameter int unsigned ADDR_WIDTH   = ct_mmu_jtlb_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = ct_mmu_jtlb_pkg::DATA_WIDTH,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  inv_all_req,
    output logic                  inv_all_done,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_bmask,
    output logic                  wr_gnt,
    input  logic                  rd0_req,
    input  logic [ADDR_WIDTH-1:0] rd0_addr,
    output logic                  rd0_gnt,
    input  logic                  rd1_req,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    output logic                  rd1_gnt,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd0_vld,
    output logic                  rd1_vld,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);
    import ct_mmu_jtlb_pkg::*;

    localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic                  sweep_we;
    logic [ADDR_WIDTH-1:0] sweep_addr;
    logic [CNT_W-1:0]      starve_cnt;
    logic                  rd_pend;
    logic                  starved;
    logic                  blocked;
    logic [1:0]            rd_s1;
    arb_src_e              src;

    ct_mmu_jtlb_sweep_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sweep (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .inv_all_req    (inv_all_req),
        .busy           (busy),
        .sweep_we       (sweep_we),
        .sweep_addr     (sweep_addr),
        .inv_all_done   (inv_all_done)
    );

    // A request arriving in IDLE blocks grants in the same cycle the sweep starts.
    assign blocked = busy | inv_all_req;
    assign rd_pend = rd0_req | rd1_req;
    assign starved = rd_pend && (starve_cnt == CNT_MAX);

    always_comb begin
        src = SRC_NONE;
        if (sweep_we) begin
            src = SRC_SWEEP;
        end else if (!blocked) begin
            if (wr_req && !starved) begin
                src = SRC_WR;
            end else if (rd0_req) begin
                src = SRC_RD0;
            end else if (rd1_req) begin
                src = SRC_RD1;
            end
        end
    end

    assign wr_gnt  = (src == SRC_WR);
    assign rd0_gnt = (src == SRC_RD0);
    assign rd1_gnt = (src == SRC_RD1);
    assign rd_data = sram_q;

    // Counts cycles a pending reader has lost to the writer.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            starve_cnt <= '0;
        end else if (!rd_pend || rd0_gnt || rd1_gnt) begin
            starve_cnt <= '0;
        end else if (wr_gnt && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            sram_cen  <= 1'b1;
            sram_gwen <= 1'b1;
            sram_wen  <= '1;
            sram_a    <= '0;
            sram_d    <= '0;
        end else begin
            case (src)
                SRC_SWEEP: begin
                    sram_cen  <= 1'b0;
                    sram_gwen <= 1'b0;
                    sram_wen  <= '0;
                    sram_a    <= sweep_addr;
                    sram_d    <= '0;
                end
                SRC_WR: begin
                    sram_cen  <= 1'b0;
                    sram_gwen <= 1'b0;
                    sram_wen  <= ~wr_bmask;
                    sram_a    <= wr_addr;
                    sram_d    <= wr_data;
                end
                SRC_RD0: begin
                    sram_cen  <= 1'b0;
                    sram_gwen <= 1'b1;
                    sram_wen  <= '1;
                    sram_a    <= rd0_addr;
                end
                SRC_RD1: begin
                    sram_cen  <= 1'b0;
                    sram_gwen <= 1'b1;
                    sram_wen  <= '1;
                    sram_a    <= rd1_addr;
                end
                default: begin
                    sram_cen  <= 1'b1;
                    sram_gwen <= 1'b1;
                    sram_wen  <= '1;
                end
            endcase
        end
    end

    // Two-stage valid pipe matching the array's one-cycle access after the pin register.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            rd_s1   <= 2'b00;
            rd0_vld <= 1'b0;
            rd1_vld <= 1'b0;
        end else begin
            rd_s1   <= {rd1_gnt, rd0_gnt};
            rd0_vld <= rd_s1[0];
            rd1_vld <= rd_s1[1];
        end
    end

endmodule

// File: tb/tb_ct_mmu_jtlb_sram_ctrl.sv
// Randomized scoreboard bench for the JTLB array controller with an SRAM macro model.
module tb_ct_mmu_jtlb_sram_ctrl;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 196;
    localparam int unsigned SL    = 4;
    localparam int unsigned DEPTH = 256;

    logic          forever_cpuclk = 1'b0;
    logic          cpurst;
    logic          inv_all_req, inv_all_done;
    logic          wr_req, wr_gnt;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data, wr_bmask;
    logic          rd0_req, rd0_gnt, rd1_req, rd1_gnt;
    logic [AW-1:0] rd0_addr, rd1_addr;
    logic [DW-1:0] rd_data;
    logic          rd0_vld, rd1_vld, busy;
    logic [AW-1:0] sram_a;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_d, sram_q;

    always #5 forever_cpuclk = ~forever_cpuclk;

    ct_mmu_jtlb_sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
        .forever_cpuclk (forever_cpuclk), .cpurst (cpurst),
        .inv_all_req (inv_all_req), .inv_all_done (inv_all_done),
        .wr_req (wr_req), .wr_addr (wr_addr), .wr_data (wr_data), .wr_bmask (wr_bmask), .wr_gnt (wr_gnt),
        .rd0_req (rd0_req), .rd0_addr (rd0_addr), .rd0_gnt (rd0_gnt),
        .rd1_req (rd1_req), .rd1_addr (rd1_addr), .rd1_gnt (rd1_gnt),
        .rd_data (rd_data), .rd0_vld (rd0_vld), .rd1_vld (rd1_vld), .busy (busy),
        .sram_a (sram_a), .sram_cen (sram_cen), .sram_gwen (sram_gwen),
        .sram_wen (sram_wen), .sram_d (sram_d), .sram_q (sram_q)
    );

    // Behavioural single-port macro: writes per bit where WEN is low, Q updates on reads.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge forever_cpuclk) begin
        if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] = (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else sram_q <= mem[sram_a];
        end
    end

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    always @(posedge forever_cpuclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [1:0]    src;   // 01 = rd0, 10 = rd1
        logic [31:0]   due;
        logic [DW-1:0] data;
    } rd_exp_t;
    rd_exp_t sbq[$];

    // Reference model state, owned by the checker process below.
    logic [DW-1:0] model_mem [DEPTH];
    bit            chk_arb = 1'b0;
    int            zero_req = 0, zero_seen = 0;
    logic [AW-1:0] hold_a = '0;
    logic [DW-1:0] hold_d = '0;
    int            losses;
    bit            pin_valid = 1'b0;
    logic          exp_cen, exp_gwen;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_wen, exp_d;
    int            e;
    bit            pend;

    // Arbitration and pin checker: decides the winner from the request rules and
    // predicts the pin drive visible in the following cycle.
    always @(negedge forever_cpuclk) begin
        if (zero_req != zero_seen) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
            zero_seen = zero_req;
        end
        if (!chk_arb) begin
            pin_valid = 1'b0;
        end else begin
            if (!pin_valid) begin
                exp_a = hold_a; exp_d = hold_d; losses = 0;
            end else begin
                chk("sram_ctl", {sram_cen, sram_gwen, sram_a}, {exp_cen, exp_gwen, exp_a});
                chk("sram_wen", sram_wen, exp_wen);
                chk("sram_d", sram_d, exp_d);
            end
            pend = rd0_req | rd1_req;
            if (wr_req && !(pend && losses >= int'(SL))) e = 1;
            else if (rd0_req) e = 2;
            else if (rd1_req) e = 3;
            else e = 0;
            chk("grant", {wr_gnt, rd0_gnt, rd1_gnt},
                (e == 1) ? 3'b100 : (e == 2) ? 3'b010 : (e == 3) ? 3'b001 : 3'b000);
            exp_cen = 1'b1; exp_gwen = 1'b1; exp_wen = '1;
            case (e)
                1: begin
                    model_mem[wr_addr] = (model_mem[wr_addr] & ~wr_bmask) | (wr_data & wr_bmask);
                    exp_cen = 1'b0; exp_gwen = 1'b0; exp_wen = ~wr_bmask;
                    exp_a = wr_addr; exp_d = wr_data;
                    losses = pend ? losses + 1 : 0;
                end
                2: begin
                    sbq.push_back('{src: 2'b01, due: cyc + 2, data: model_mem[rd0_addr]});
                    exp_cen = 1'b0; exp_a = rd0_addr; losses = 0;
                end
                3: begin
                    sbq.push_back('{src: 2'b10, due: cyc + 2, data: model_mem[rd1_addr]});
                    exp_cen = 1'b0; exp_a = rd1_addr; losses = 0;
                end
                default: losses = 0;
            endcase
            pin_valid = 1'b1;
        end
    end

    // Read-response monitor: pops the scoreboard whenever a valid appears.
    rd_exp_t h;
    always @(negedge forever_cpuclk) begin
        if (cpurst) begin
            sbq.delete();
        end else if (rd0_vld || rd1_vld) begin
            if (sbq.size() == 0) begin
                chk("rd_unexpected", {rd1_vld, rd0_vld}, 2'b00);
            end else begin
                h = sbq.pop_front();
                chk("rd_src_cycle", {rd1_vld, rd0_vld, 32'(cyc)}, {h.src, h.due});
                chk("rd_data", rd_data, h.data);
            end
        end else if (sbq.size() > 0 && sbq[0].due <= 32'(cyc)) begin
            h = sbq.pop_front();
            chk("rd_missing", {rd1_vld, rd0_vld}, h.src);
        end
    end

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] v = '0;
        for (int i = 0; i < 7; i++) v = {v[DW-33:0], 32'($urandom)};
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge forever_cpuclk); #1; end
    endtask

    // One cycle: requesters drop their request after seeing a grant.
    task automatic step();
        logic gw, g0, g1;
        @(negedge forever_cpuclk);
        gw = wr_gnt; g0 = rd0_gnt; g1 = rd1_gnt;
        @(posedge forever_cpuclk); #1;
        if (gw) wr_req = 1'b0;
        if (g0) rd0_req = 1'b0;
        if (g1) rd1_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (wr_req || rd0_req || rd1_req); i++) step();
        chk("drain_timeout", {wr_req, rd0_req, rd1_req}, 3'b000);
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            if (!wr_req && $urandom_range(0, 99) < 40) begin
                wr_req = 1'b1; wr_addr = AW'($urandom_range(0, 15)); wr_data = rnd_data();
                wr_bmask = ($urandom_range(0, 3) == 0) ? {DW{1'b1}} : rnd_data();
            end
            if (!rd0_req && $urandom_range(0, 99) < 45) begin
                rd0_req = 1'b1; rd0_addr = AW'($urandom_range(0, 15));
            end
            if (!rd1_req && $urandom_range(0, 99) < 25) begin
                rd1_req = 1'b1; rd1_addr = AW'($urandom_range(0, 15));
            end else if (rd1_req && $urandom_range(0, 99) < 5) begin
                rd1_req = 1'b0;
            end
        end
        drain();
    endtask

    // Full invalidate: counts busy cycles, zeroing writes in address order, done pulses, grants.
    task automatic do_sweep(input int restart_at, input bit with_reqs);
        int nbusy = 0, nwr = 0, ndone = 0, ngnt = 0, nbad = 0;
        bit started = 0, pulsed = 0, done_seen = 0, fin = 0;
        int exp_busy = (restart_at >= 0) ? 513 : 257;
        int exp_wr   = (restart_at >= 0) ? 512 : 256;
        inv_all_req = 1'b1;
        if (with_reqs) begin
            wr_req = 1'b1; wr_addr = AW'($urandom); wr_data = rnd_data(); wr_bmask = '1;
            rd0_req = 1'b1; rd0_addr = AW'($urandom); rd1_req = 1'b1; rd1_addr = AW'($urandom);
        end
        for (int c = 0; c < 1200; c++) begin
            @(negedge forever_cpuclk);
            if (wr_gnt || rd0_gnt || rd1_gnt) ngnt++;
            if (inv_all_done) begin ndone++; done_seen = 1; end
            if (!sram_cen && !sram_gwen) begin
                if (sram_wen != '0 || sram_d != '0 || sram_a != AW'(nwr)) nbad++;
                nwr++;
            end
            if (busy) begin
                nbusy++; started = 1;
            end else if (started) begin
                fin = 1; break;
            end
            @(posedge forever_cpuclk); #1;
            inv_all_req = 1'b0;
            if (restart_at >= 0 && !pulsed && nwr == restart_at) begin
                inv_all_req = 1'b1; pulsed = 1;
            end
            if (done_seen) begin wr_req = 1'b0; rd0_req = 1'b0; rd1_req = 1'b0; end
        end
        @(posedge forever_cpuclk); #1;
        inv_all_req = 1'b0; wr_req = 1'b0; rd0_req = 1'b0; rd1_req = 1'b0;
        chk("sweep_finished", 1'(fin), 1'b1);
        chk("sweep_busy_cycles", nbusy, exp_busy);
        chk("sweep_writes", nwr, exp_wr);
        chk("sweep_done_pulses", ndone, 1);
        chk("sweep_grants", ngnt, 0);
        chk("sweep_addr_order", nbad, 0);
    endtask

    initial begin
        logic [11:0] seq;
        int nb, nd;
        bit hit;
        cpurst = 1'b1; inv_all_req = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_bmask = '0;
        rd0_req = 1'b0; rd0_addr = '0; rd1_req = 1'b0; rd1_addr = '0;
        repeat (3) @(posedge forever_cpuclk);
        @(negedge forever_cpuclk);
        chk("rst_cen_gwen", {sram_cen, sram_gwen}, 2'b11);
        chk("rst_wen", sram_wen, {DW{1'b1}});
        chk("rst_a_d", {sram_a, sram_d}, '0);
        chk("rst_flags", {wr_gnt, rd0_gnt, rd1_gnt, rd0_vld, rd1_vld, busy, inv_all_done}, 7'b0);
        @(posedge forever_cpuclk); #1;
        cpurst = 1'b0;
        idle(2);

        // Initial invalidate with every requester held: nothing may be granted.
        do_sweep(-1, 1'b1);
        hold_a = '1; hold_d = '0; zero_req++;
        idle(1);
        chk_arb = 1'b1;

        wr_req = 1'b1; wr_addr = 8'h12; wr_data = DW'(12'hABC); wr_bmask = '1;
        drain();
        rd0_req = 1'b1; rd0_addr = 8'h12;
        drain();
        idle(4);
        chk("array_0x12", mem[8'h12], DW'(12'hABC));

        // Writer held against a held reader: four writes, then the forced read, then the writer.
        wr_req = 1'b1; wr_addr = 8'h40; wr_data = '1; wr_bmask = DW'(4'hF);
        rd0_req = 1'b1; rd0_addr = 8'h40;
        seq = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge forever_cpuclk);
            seq = {seq[9:0], wr_gnt ? 2'd1 : rd0_gnt ? 2'd2 : rd1_gnt ? 2'd3 : 2'd0};
            @(posedge forever_cpuclk); #1;
        end
        wr_req = 1'b0; rd0_req = 1'b0;
        chk("starve_seq", seq, {2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1});
        idle(4);
        chk("array_0x40", mem[8'h40], DW'(4'hF));

        rd0_req = 1'b1; rd0_addr = 8'h12; rd1_req = 1'b1; rd1_addr = 8'h40;
        seq = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge forever_cpuclk);
            seq = {seq[9:0], rd0_gnt ? 2'd2 : rd1_gnt ? 2'd3 : 2'd0};
            @(posedge forever_cpuclk); #1;
            if (i == 0) rd0_req = 1'b0;
        end
        rd1_req = 1'b0;
        chk("dual_read_order", seq[3:0], {2'd2, 2'd3});
        idle(4);

        rand_cycles(600);
        idle(4);

        // Second request mid-sweep forces another full pass.
        chk_arb = 1'b0;
        idle(1);
        do_sweep(100, 1'b0);
        hold_a = '1; hold_d = '0; zero_req++;
        idle(1);
        chk_arb = 1'b1;
        rand_cycles(250);
        idle(4);

        // Reset in the middle of a sweep: no done pulse, later sweep starts at index 0.
        chk_arb = 1'b0;
        idle(1);
        inv_all_req = 1'b1;
        hit = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge forever_cpuclk);
            if (!sram_cen && !sram_gwen && sram_a == 8'd50) begin hit = 1; break; end
            @(posedge forever_cpuclk); #1;
            inv_all_req = 1'b0;
        end
        chk("reach_index50", 1'(hit), 1'b1);
        @(posedge forever_cpuclk); #1;
        inv_all_req = 1'b0; cpurst = 1'b1;
        @(posedge forever_cpuclk); #1;
        cpurst = 1'b0;
        @(negedge forever_cpuclk);
        chk("rst_mid_sweep", {sram_cen, busy, inv_all_done, sram_a}, {1'b1, 1'b0, 1'b0, 8'h00});
        nb = 0; nd = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge forever_cpuclk);
            if (busy) nb++;
            if (inv_all_done) nd++;
        end
        chk("rst_no_done", {nb, nd}, 64'd0);
        @(posedge forever_cpuclk); #1;
        do_sweep(-1, 1'b0);
        hold_a = '1; hold_d = '0; zero_req++;
        idle(1);
        chk_arb = 1'b1;
        rand_cycles(200);
        idle(6);
        chk("sb_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
